operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Register-file read stage directly upstream of the ALU operand mux array.
//  Holds the 16 x 16-bit general registers and a pending-write scoreboard.
//  Presents registered Rdest/Rsrc operands plus a sign- or zero-extended immediate,
//  which the mux array selects between.
//  Handshakes are valid/ready in both directions; the write-back port retires results.
// PARAMETERS
//  DATA_WIDTH  16  register / operand width
//  REG_COUNT   16  number of general registers
//  ADDR_WIDTH  4   register address width; REG_COUNT == 2**ADDR_WIDTH
//  IMM_WIDTH   8   raw immediate width from the decoder
// PORTS
//  clk           in   1           single clock, rising edge
//  reset         in   1           synchronous, active-high
//  in_valid      in   1           decoder presents an instruction
//  in_ready      out  1           stage accepts it this cycle
//  rdest_addr    in   ADDR_WIDTH  destination / first source register
//  rsrc_addr     in   ADDR_WIDTH  second source register
//  imm           in   IMM_WIDTH   raw immediate
//  imm_signed    in   1           1 = sign-extend imm, 0 = zero-extend
//  uses_rsrc     in   1           0 = Rsrc is not read (immediate form)
//  claim_dest    in   1           instruction will write rdest_addr
//  out_valid     out  1           operands valid
//  out_ready     in   1           ALU side consumes operands
//  op_dest       out  DATA_WIDTH  value of rdest_addr
//  op_src        out  DATA_WIDTH  value of rsrc_addr (0 when uses_rsrc = 0)
//  op_imm        out  DATA_WIDTH  extended immediate
//  out_dest_addr out  ADDR_WIDTH  rdest_addr carried forward
//  wb_en         in   1           write-back strobe
//  wb_addr       in   ADDR_WIDTH  write-back register
//  wb_data       in   DATA_WIDTH  write-back value
// BEHAVIOUR
//  - Reset: all registers = 0, scoreboard = 0, out_valid = 0.
//    op_dest, op_src, op_imm, and out_dest_addr = 0.
//  - No hardwired-zero register; r0 is a general register.
//  - hazard = pending[rdest_addr] | (uses_rsrc & pending[rsrc_addr]).
//    The pending bits used here are taken after masking wb_addr when wb_en = 1
//    (a same-cycle write-back clears the hazard).
//  - in_ready = ~hazard & (~out_valid | out_ready). It is combinational and
//    asserted during reset.
//  - Accept = in_valid & in_ready.
//    On accept, all outputs load at the next edge (latency 1) and out_valid <= 1.
//  - Output hold: if out_valid & ~out_ready, every output holds.
//    If out_ready & ~accept, out_valid <= 0.
//  - Read bypass: if wb_en and wb_addr equals a read address in the accept cycle,
//    that operand loads wb_data instead of the array value.
//  - Write: wb_en writes reg[wb_addr] <= wb_data and clears pending[wb_addr].
//    This happens regardless of the handshake.
//  - Claim: accept & claim_dest sets pending[rdest_addr].
//    If the same address is cleared by wb_en in the same cycle, the set wins.
//  - Immediate: imm_signed = 1 replicates imm[IMM_WIDTH-1]; otherwise upper bits are 0.
//  - wb_en to a non-pending register is legal: the data is written and the bit stays 0.
//  - Reset mid-operation discards the held output and clears all pending claims.
//    A wb_en coinciding with reset is ignored.
// TESTING
//  1. Reset, then read r3/r4 with uses_rsrc = 1 -> 1 cycle later out_valid = 1,
//     op_dest = 0, op_src = 0.
//  2. wb_en r5 = 0x1234, then read r5 -> op_dest = 0x1234. In a separate run,
//     issue wb_en r5 = 0x1234 in the same cycle as the read -> op_dest = 0x1234
//     (bypass).
//  3. imm = 0x80: imm_signed = 1 -> op_imm = 0xFF80; imm_signed = 0 -> op_imm = 0x0080.
//  4. Claim r2, then issue a read of r2 -> in_ready = 0 until wb_en r2 = 0x00AA.
//     Accept occurs in that same cycle; op_dest = 0x00AA.
//  5. out_ready = 0 for 3 cycles with in_valid = 1 -> outputs stable, in_ready = 0.
//     Release -> back-to-back accepts at 1 per cycle.
//  6. Claim r7 + wb_en r7 in the same cycle -> pending[r7] stays 1.
//     Reset -> pending clear, r7 = 0.

Source files
------------

// File: rtl/operand_fetch.sv
// Register-file read stage: 16x16 registers, pending-write scoreboard, registered operands.
// Latency 1 from accept; outputs hold while out_ready is low; in_ready drops on hazard or held output.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int IMM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rdest_addr,
  input  logic [ADDR_WIDTH-1:0] rsrc_addr,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic                  imm_signed,
  input  logic                  uses_rsrc,
  input  logic                  claim_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] op_dest,
  output logic [DATA_WIDTH-1:0] op_src,
  output logic [DATA_WIDTH-1:0] op_imm,
  output logic [ADDR_WIDTH-1:0] out_dest_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] dest;
  } opnd_t;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  pending;
  logic [REG_COUNT-1:0]  wb_mask;
  logic [REG_COUNT-1:0]  claim_mask;
  logic [REG_COUNT-1:0]  pending_eff;
  logic                  hazard;
  logic                  accept;
  logic                  valid_q;
  opnd_t                 opnd_q;
  opnd_t                 opnd_d;
  logic [DATA_WIDTH-1:0] dest_rd;
  logic [DATA_WIDTH-1:0] src_rd;

  always_comb begin
    wb_mask = '0;
    if (wb_en) wb_mask[wb_addr] = 1'b1;
  end

  // A write-back landing this cycle already satisfies the reader.
  assign pending_eff = pending & ~wb_mask;
  assign hazard      = pending_eff[rdest_addr] | (uses_rsrc & pending_eff[rsrc_addr]);
  assign in_ready    = reset | (~hazard & (~valid_q | out_ready));
  assign accept      = in_valid & in_ready & ~reset;

  always_comb begin
    claim_mask = '0;
    if (accept && claim_dest) claim_mask[rdest_addr] = 1'b1;
  end

  assign dest_rd = (wb_en && (wb_addr == rdest_addr)) ? wb_data : regs[rdest_addr];
  assign src_rd  = (wb_en && (wb_addr == rsrc_addr))  ? wb_data : regs[rsrc_addr];

  always_comb begin
    opnd_d           = '0;
    opnd_d.dest_addr = rdest_addr;
    opnd_d.dest      = dest_rd;
    opnd_d.src       = uses_rsrc ? src_rd : '0;
    opnd_d.imm       = {{(DATA_WIDTH-IMM_WIDTH){imm_signed & imm[IMM_WIDTH-1]}}, imm};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Claim is ORed after the write-back clear so a same-address set wins.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~wb_mask) | claim_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      opnd_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      opnd_q  <= opnd_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign op_dest       = opnd_q.dest;
  assign op_src        = opnd_q.src;
  assign op_imm        = opnd_q.imm;
  assign out_dest_addr = opnd_q.dest_addr;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scenarios plus randomized traffic, every cycle checked against a behavioural model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, imm_signed, uses_rsrc, claim_dest;
  logic [3:0]  rdest_addr, rsrc_addr, out_dest_addr, wb_addr;
  logic [7:0]  imm;
  logic        out_valid, out_ready, wb_en;
  logic [15:0] op_dest, op_src, op_imm, wb_data;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int unsigned m_reg [16];
  bit          m_pend [16];
  bit          m_ov;
  logic [15:0] m_dest, m_src, m_imm;
  logic [3:0]  m_daddr;
  bit          m_rdy;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rdest_addr(rdest_addr), .rsrc_addr(rsrc_addr), .imm(imm), .imm_signed(imm_signed),
    .uses_rsrc(uses_rsrc), .claim_dest(claim_dest), .out_valid(out_valid),
    .out_ready(out_ready), .op_dest(op_dest), .op_src(op_src), .op_imm(op_imm),
    .out_dest_addr(out_dest_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input int a);
    // a register is blocked if claimed and not being written back right now
    return m_pend[a] && !(wb_en && int'(wb_addr) == a);
  endfunction

  function automatic logic [15:0] read_val(input int a);
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[a][15:0];
  endfunction

  function automatic logic [15:0] ext_imm();
    int v;
    v = int'(imm);
    if (imm_signed && v >= 128) v = v - 256;
    return v[15:0];
  endfunction

  task automatic idle();
    reset = 0; in_valid = 0; rdest_addr = 0; rsrc_addr = 0; imm = 0; imm_signed = 0;
    uses_rsrc = 0; claim_dest = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic read(input int d, input int s, input bit u, input bit c);
    in_valid = 1; rdest_addr = 4'(d); rsrc_addr = 4'(s); uses_rsrc = u; claim_dest = c;
  endtask

  task automatic wb(input int a, input int unsigned v);
    wb_en = 1; wb_addr = 4'(a); wb_data = 16'(v);
  endtask

  // One clock: check in_ready mid-cycle, advance model at the edge, check outputs after it.
  task automatic cycle();
    bit acc;
    logic [15:0] nd, ns, ni;
    #4;
    m_rdy = reset || (!(busy(int'(rdest_addr)) || (uses_rsrc && busy(int'(rsrc_addr))))
                      && (!m_ov || out_ready));
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    acc = !reset && in_valid && m_rdy;
    nd = read_val(int'(rdest_addr));
    ns = uses_rsrc ? read_val(int'(rsrc_addr)) : 16'h0;
    ni = ext_imm();
    @(posedge clk);
    if (reset) begin
      foreach (m_reg[i]) begin m_reg[i] = 0; m_pend[i] = 0; end
      m_ov = 0; m_dest = 0; m_src = 0; m_imm = 0; m_daddr = 0;
    end else begin
      if (acc) begin
        m_ov = 1; m_dest = nd; m_src = ns; m_imm = ni; m_daddr = rdest_addr;
      end else if (out_ready) m_ov = 0;
      if (wb_en) begin m_reg[wb_addr] = wb_data; m_pend[wb_addr] = 0; end
      if (acc && claim_dest) m_pend[rdest_addr] = 1;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    chk("op_dest", {16'b0, op_dest}, {16'b0, m_dest});
    chk("op_src", {16'b0, op_src}, {16'b0, m_src});
    chk("op_imm", {16'b0, op_imm}, {16'b0, m_imm});
    chk("out_dest_addr", {28'b0, out_dest_addr}, {28'b0, m_daddr});
  endtask

  initial begin
    logic [15:0] hold_dest, hold_imm;
    m_ov = 0;
    idle(); reset = 1; cycle(); cycle();
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);

    // 1: read r3/r4 after reset
    idle(); read(3, 4, 1, 0); cycle();
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_dest", {16'b0, op_dest}, 32'h0);
    chk("t1_src", {16'b0, op_src}, 32'h0);

    // 2: write then read, then bypass in a fresh run
    idle(); wb(5, 16'h1234); cycle();
    idle(); read(5, 0, 0, 0); cycle();
    chk("t2_read", {16'b0, op_dest}, 32'h1234);
    idle(); reset = 1; cycle();
    idle(); read(5, 5, 1, 0); wb(5, 16'h1234); cycle();
    chk("t2_bypass", {16'b0, op_dest}, 32'h1234);
    chk("t2_bypass_src", {16'b0, op_src}, 32'h1234);

    // 3: immediate extension
    idle(); read(0, 0, 0, 0); imm = 8'h80; imm_signed = 1; cycle();
    chk("t3_sext", {16'b0, op_imm}, 32'hFF80);
    imm_signed = 0; cycle();
    chk("t3_zext", {16'b0, op_imm}, 32'h0080);

    // 4: claim r2, blocked read until write-back in the same cycle
    idle(); read(2, 0, 0, 1); cycle();
    idle(); read(2, 0, 0, 0); cycle();
    chk("t4_blocked", {31'b0, in_ready}, 32'd0);
    cycle();
    wb(2, 16'h00AA); cycle();
    chk("t4_dest", {16'b0, op_dest}, 32'h00AA);

    // 5: backpressure for 3 cycles, then back-to-back accepts
    idle(); read(1, 2, 1, 0); imm = 8'h11; cycle();
    hold_dest = op_dest; hold_imm = op_imm;
    out_ready = 0; imm = 8'h22;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_stall_ready", {31'b0, in_ready}, 32'd0);
      chk("t5_hold_imm", {16'b0, op_imm}, {16'b0, hold_imm});
      chk("t5_hold_dest", {16'b0, op_dest}, {16'b0, hold_dest});
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      imm = 8'(8'h30 + i); cycle();
      chk("t5_b2b_imm", {16'b0, op_imm}, 32'h30 + i);
      chk("t5_b2b_valid", {31'b0, out_valid}, 32'd1);
    end

    // 6: claim and write-back of r7 together keep r7 pending; reset clears it
    idle(); read(7, 0, 0, 1); wb(7, 16'h0777); cycle();
    idle(); read(7, 0, 0, 0); cycle();
    chk("t6_pending", {31'b0, in_ready}, 32'd0);
    idle(); reset = 1; wb(7, 16'hBEEF); cycle();
    idle(); read(7, 0, 0, 0); cycle();
    chk("t6_after_reset", {16'b0, op_dest}, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset      = ($urandom_range(0, 99) == 0);
      in_valid   = $urandom_range(0, 3) != 0;
      rdest_addr = 4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 15));
      rsrc_addr  = 4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 15));
      imm        = 8'($urandom);
      imm_signed = 1'($urandom);
      uses_rsrc  = 1'($urandom);
      claim_dest = $urandom_range(0, 2) == 0;
      out_ready  = $urandom_range(0, 3) != 0;
      wb_en      = 1'($urandom);
      wb_addr    = 4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 15));
      wb_data    = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
